// File: rtl/pci_target.sv
// PCI target with 8 x 32-bit word storage at byte range 0x20-0x3F.
// It supports burst reads and writes, disconnects at the last word and master-aborts unclaimed cycles.
module pci_target (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Frame,
  input  logic        Irdy,
  output logic        Trdy,
  inout  wire  [31:0] Address,
  input  logic [3:0]  Cbe,
  output logic        Devsel,
  output logic        Stop
);

  localparam int DATA_W = 32;
  localparam int WORDS  = 8;

  typedef enum logic [2:0] {IDLE, BUSY, TURN, DATA, DONE} state_t;

  state_t              state_q;
  logic [2:0]          idx_q;
  logic                rd_q;
  logic                trdy_q;
  logic                devsel_q;
  logic                stop_q;
  logic                oe_q;
  logic [DATA_W-1:0]   dout_q;
  logic [DATA_W-1:0]   mem_q [WORDS];

  logic [29:0]         word_addr_d;
  logic [2:0]          idx_nx_d;
  logic                addr_hit_d;
  logic                rd_cmd_d;
  logic                wr_cmd_d;

  // Active-low byte enables: a 0 in be_n selects the new byte.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [3:0]        be_n);
    logic [DATA_W-1:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = be_n[b] ? old_w[8*b +: 8] : new_w[8*b +: 8];
    end
    return m;
  endfunction

  assign word_addr_d = 30'(Address >> 2);
  assign addr_hit_d  = (word_addr_d[29:3] == 27'h0000001);
  assign rd_cmd_d    = (Cbe == 4'b0110) || (Cbe == 4'b0010);
  assign wr_cmd_d    = (Cbe == 4'b0111) || (Cbe == 4'b0011);
  assign idx_nx_d    = idx_q + 3'd1;

  assign Address = oe_q ? dout_q : 'z;
  assign Trdy    = trdy_q;
  assign Devsel  = devsel_q;
  assign Stop    = stop_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      rd_q     <= 1'b0;
      trdy_q   <= 1'b1;
      devsel_q <= 1'b1;
      stop_q   <= 1'b1;
      oe_q     <= 1'b0;
      dout_q   <= '0;
      for (int w = 0; w < WORDS; w++) begin
        mem_q[w] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!Frame) begin
            idx_q <= word_addr_d[2:0];
            rd_q  <= rd_cmd_d;
            if (addr_hit_d && wr_cmd_d) begin
              state_q  <= DATA;
              devsel_q <= 1'b0;
              trdy_q   <= 1'b0;
              stop_q   <= (word_addr_d[2:0] != 3'd7);
            end else if (addr_hit_d && rd_cmd_d) begin
              state_q  <= TURN;
              devsel_q <= 1'b0;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (Frame && Irdy) begin
            state_q <= IDLE;
          end
        end
        TURN: begin
          state_q <= DATA;
          trdy_q  <= 1'b0;
          oe_q    <= 1'b1;
          dout_q  <= mem_q[idx_q];
          stop_q  <= (idx_q != 3'd7);
        end
        DATA: begin
          // Trdy high inside DATA means the last word went out with Stop; wait for Frame to drop.
          if (trdy_q) begin
            if (Frame) begin
              state_q  <= DONE;
              devsel_q <= 1'b1;
              stop_q   <= 1'b1;
            end
          end else if (!Irdy) begin
            if (!rd_q) begin
              mem_q[idx_q] <= merge_bytes(mem_q[idx_q], Address, Cbe);
            end
            if (Frame) begin
              state_q  <= DONE;
              trdy_q   <= 1'b1;
              devsel_q <= 1'b1;
              stop_q   <= 1'b1;
              oe_q     <= 1'b0;
            end else if (idx_q == 3'd7) begin
              trdy_q <= 1'b1;
              oe_q   <= 1'b0;
            end else begin
              idx_q  <= idx_nx_d;
              dout_q <= mem_q[idx_nx_d];
              stop_q <= (idx_nx_d != 3'd7);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pci_target.sv
// Scoreboard bench for pci_target: a reference memory predicts read data, queued at stimulus time.
module tb_pci_target;

  localparam logic [31:0] PARK = 32'h5A5A_A5A5;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Frame;
  logic        Irdy;
  logic [3:0]  Cbe;
  wire         Trdy;
  wire         Devsel;
  wire         Stop;
  wire  [31:0] Address;

  logic        tb_oe;
  logic [31:0] tb_ad;

  logic [31:0] model_q [8];
  logic [31:0] sb [$];
  logic [31:0] wdat [8];
  logic [3:0]  wbe [8];

  int n_vec = 0;
  int n_bad = 0;

  assign Address = tb_oe ? tb_ad : 'z;

  always #5 Clk = ~Clk;

  pci_target dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Frame  (Frame),
    .Irdy   (Irdy),
    .Trdy   (Trdy),
    .Address(Address),
    .Cbe    (Cbe),
    .Devsel (Devsel),
    .Stop   (Stop)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic dv, input logic tr, input logic st);
    chk({tag, "_devsel"}, {31'd0, Devsel}, {31'd0, dv});
    chk({tag, "_trdy"},   {31'd0, Trdy},   {31'd0, tr});
    chk({tag, "_stop"},   {31'd0, Stop},   {31'd0, st});
  endtask

  // Stop is only defined for the word-7 phase when the master still holds Frame low.
  task automatic chk_stop(input string tag, input int i, input bit last);
    if (!(i == 7 && last)) begin
      chk(tag, {31'd0, Stop}, (i == 7) ? 32'd0 : 32'd1);
    end
  endtask

  // The bench parks a pattern on AD; seeing it intact proves the target is not driving.
  task automatic chk_released(input string tag);
    tb_oe = 1'b1;
    tb_ad = PARK;
    #1;
    chk(tag, Address, PARK);
  endtask

  task automatic finish_txn(input string tag, input bit stopped);
    if (stopped) begin
      chk_ctl({tag, "_hold"}, 1'b0, 1'b1, 1'b0);
      chk_released({tag, "_hold_z"});
      Frame = 1'b1;
      Irdy  = 1'b1;
      tick();
    end
    chk_ctl({tag, "_done"}, 1'b1, 1'b1, 1'b1);
    chk_released({tag, "_done_z"});
    Frame = 1'b1;
    Irdy  = 1'b1;
    tick();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] cmd, input int n);
    int  idx;
    int  cnt;
    int  i;
    bit  last;
    idx = int'(addr[4:2]);
    cnt = (n < 8 - idx) ? n : 8 - idx;
    Frame = 1'b0; Irdy = 1'b1; tb_oe = 1'b1; tb_ad = addr; Cbe = cmd;
    tick();
    for (int t = 0; t < cnt; t++) begin
      i    = idx + t;
      last = (t == n - 1);
      chk("wr_devsel", {31'd0, Devsel}, 32'd0);
      chk("wr_trdy",   {31'd0, Trdy},   32'd0);
      chk_stop("wr_stop", i, last);
      tb_ad = wdat[t]; Cbe = wbe[t]; Irdy = 1'b0; Frame = last;
      tick();
      for (int b = 0; b < 4; b++) begin
        if (!wbe[t][b]) model_q[i][8*b +: 8] = wdat[t][8*b +: 8];
      end
    end
    Cbe = 4'b0000;
    finish_txn("wr", n > cnt);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] cmd, input int n,
                         input int wait_t);
    int          idx;
    int          cnt;
    int          i;
    bit          last;
    logic [31:0] exp;
    idx = int'(addr[4:2]);
    cnt = (n < 8 - idx) ? n : 8 - idx;
    for (int t = 0; t < cnt; t++) sb.push_back(model_q[idx + t]);
    Frame = 1'b0; Irdy = 1'b1; tb_oe = 1'b1; tb_ad = addr; Cbe = cmd;
    tick();
    chk_ctl("rd_turn", 1'b0, 1'b1, 1'b1);
    chk("rd_turn_z", Address, addr);
    tb_oe = 1'b0; Cbe = 4'b0000;
    tick();
    for (int t = 0; t < cnt; t++) begin
      i    = idx + t;
      last = (t == n - 1);
      exp  = sb.pop_front();
      chk("rd_devsel", {31'd0, Devsel}, 32'd0);
      chk("rd_trdy",   {31'd0, Trdy},   32'd0);
      chk_stop("rd_stop", i, last);
      chk("rd_data", Address, exp);
      if (t == wait_t) begin
        Irdy = 1'b1; Frame = 1'b0;
        tick();
        chk("rd_wait_trdy", {31'd0, Trdy}, 32'd0);
        chk("rd_wait_data", Address, exp);
      end
      Irdy = 1'b0; Frame = last;
      tick();
    end
    finish_txn("rd", n > cnt);
  endtask

  task automatic do_unclaimed(input logic [31:0] addr, input logic [3:0] cmd);
    Frame = 1'b0; Irdy = 1'b1; tb_oe = 1'b1; tb_ad = addr; Cbe = cmd;
    tick();
    chk_ctl("ma_addr", 1'b1, 1'b1, 1'b1);
    chk("ma_z0", Address, addr);
    Irdy = 1'b0; tb_ad = 32'h1234_5678; Cbe = 4'b0000;
    tick();
    chk_ctl("ma_data", 1'b1, 1'b1, 1'b1);
    chk("ma_z1", Address, 32'h1234_5678);
    Frame = 1'b1;
    tick();
    chk_ctl("ma_last", 1'b1, 1'b1, 1'b1);
    Irdy = 1'b1;
    tick();
    chk_ctl("ma_idle", 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int w = 0; w < 8; w++) model_q[w] = 32'h0;
    tb_oe = 1'b1; tb_ad = PARK; Frame = 1'b1; Irdy = 1'b1; Cbe = 4'b0000; Rst = 1'b1;
    tick();
    chk_ctl("rst", 1'b1, 1'b1, 1'b1);
    chk_released("rst_z");
    Rst = 1'b0;
    tick();

    do_read(32'h0000_0020, 4'b0110, 1, -1);

    wdat[0] = 32'h1111_1111; wbe[0] = 4'b0000;
    wdat[1] = 32'h0000_1111; wbe[1] = 4'b0000;
    do_write(32'h0000_0020, 4'b0111, 2);
    do_read(32'h0000_0020, 4'b0010, 2, 1);

    do_unclaimed(32'h0000_1F41, 4'b0010);
    do_unclaimed(32'h0000_0020, 4'b0001);
    do_unclaimed(32'h0000_0040, 4'b0110);

    wdat[0] = 32'h4444_0004; wbe[0] = 4'b0000;
    wdat[1] = 32'h5555_0005; wbe[1] = 4'b0000;
    wdat[2] = 32'h6666_0006; wbe[2] = 4'b0000;
    wdat[3] = 32'h7777_0007; wbe[3] = 4'b0000;
    do_write(32'h0000_0030, 4'b0011, 4);
    do_read(32'h0000_0030, 4'b0110, 6, 2);

    wdat[0] = 32'h1111_0000; wbe[0] = 4'b0000;
    do_write(32'h0000_0028, 4'b0111, 1);
    wdat[0] = 32'hAABB_CCDD; wbe[0] = 4'b1100;
    do_write(32'h0000_0028, 4'b0111, 1);
    do_read(32'h0000_002B, 4'b0110, 1, -1);

    wdat[0] = 32'h0F0F_7777; wbe[0] = 4'b0000;
    wdat[1] = 32'hBAD0_0001; wbe[1] = 4'b0000;
    wdat[2] = 32'hBAD0_0002; wbe[2] = 4'b0000;
    do_write(32'h0000_003C, 4'b0111, 3);
    do_read(32'h0000_003C, 4'b0010, 1, -1);
    do_read(32'h0000_0020, 4'b0110, 1, -1);

    // Reset lands on a live write data phase: that phase must not reach memory.
    Frame = 1'b0; Irdy = 1'b1; tb_oe = 1'b1; tb_ad = 32'h0000_0020; Cbe = 4'b0111;
    tick();
    tb_ad = 32'hDEAD_BEEF; Cbe = 4'b0000; Irdy = 1'b0;
    tick();
    model_q[0] = 32'hDEAD_BEEF;
    tb_ad = 32'hCAFE_F00D; Rst = 1'b1;
    tick();
    chk_ctl("abort", 1'b1, 1'b1, 1'b1);
    chk_released("abort_z");
    Rst = 1'b0; Frame = 1'b1; Irdy = 1'b1;
    for (int w = 0; w < 8; w++) model_q[w] = 32'h0;
    tick();
    do_read(32'h0000_0020, 4'b0110, 2, -1);
    do_read(32'h0000_0030, 4'b0110, 1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pci_target.md
PCI_TARGET -- requirements
Module: pci_target

Interface
REQ-001 SHALL: Clk  input  1  single clock; every flop updates on the rising edge.
REQ-002 SHALL: Rst  input  1  reset; synchronous and active-high.
REQ-003 SHALL: Frame  input  1  master FRAME#, active-low.
REQ-004 SHALL: Irdy  input  1  master IRDY#, active-low.
REQ-005 SHALL: Trdy  output  1  target TRDY#, active-low.
REQ-006 SHALL: Address  inout  32  multiplexed AD bus; driven by this block only during read data phases, otherwise high-Z.
REQ-007 SHALL: Cbe  input  4  C/BE#: command in address phase, active-low byte enables in data phases.
REQ-008 SHALL: Devsel  output  1  DEVSEL#, active-low.
REQ-009 SHALL: Stop  output  1  STOP#, active-low.

Function
REQ-010 SHALL: internal storage is 8 x 32-bit words, word index = AD[4:2] of the address phase; AD[1:0] ignored.
REQ-011 SHALL: device claims address iff AD[31:5] == 27'h0000001 (byte range 0x20-0x3F); any other address (e.g. 0x00001F41) is not claimed.
REQ-012 SHALL: read commands are Cbe 4'b0110 and 4'b0010; write commands are 4'b0111 and 4'b0011; any other command is not claimed.
REQ-013 SHALL: address phase = rising edge where FSM is IDLE and Frame==0; AD and Cbe are latched on that edge.
REQ-014 SHALL: FSM states IDLE, BUSY (unclaimed, wait for bus idle), TURN (read turnaround), DATA, DONE.
REQ-015 SHALL: IDLE -> BUSY if address phase not claimed; BUSY -> IDLE on the edge where Frame==1 and Irdy==1; Devsel/Trdy/Stop stay 1 throughout (master abort).
REQ-016 SHALL: claimed write: IDLE -> DATA; Devsel=0 and Trdy=0 in the cycle after the address phase.
REQ-017 SHALL: claimed read: IDLE -> TURN (Devsel=0, Trdy=1, AD high-Z for one cycle) -> DATA (AD driven with Mem[index], Trdy=0).
REQ-018 SHALL: a data transfer occurs on each edge in DATA where Irdy==0 and Trdy==0; Irdy==1 inserts wait states with no index change and no write.
REQ-019 SHALL: write transfer updates only bytes whose Cbe bit is 0 (Cbe[0] -> bits 7:0 ... Cbe[3] -> bits 31:24).
REQ-020 SHALL: read data is the full 32-bit word regardless of Cbe; after each transfer index increments by 1 and AD shows the new word in the next cycle.
REQ-021 SHALL: transfer with Frame==1 is the final one; next state DONE.
REQ-022 SHALL: when index==7 in DATA with Frame==0, Stop=0 is asserted together with Trdy=0 (disconnect with data); after that transfer, Trdy=1, Stop=0, Devsel=0 held until edge with Frame==1, then DONE; index never wraps.
REQ-023 SHALL: DONE lasts one cycle: Devsel=Trdy=Stop=1, AD high-Z; then IDLE.
REQ-024 SHALL: AD is released (high-Z) in the cycle after the final read transfer.
REQ-025 SHALL: a new address phase is accepted only from IDLE (no back-to-back without DONE).

Reset
REQ-026 SHALL: Rst==1 sampled on an edge forces IDLE, Trdy=Devsel=Stop=1, AD high-Z, index=0, all 8 memory words to 32'h00000000.
REQ-027 SHALL: reset asserted mid-transaction aborts it immediately on that edge; no partial write of the current data phase.
REQ-028 SHALL: outputs are never X after the first reset edge.

Verification
REQ-029 SHALL: Rst=1 one edge -> Devsel=Trdy=Stop=1, AD=Z; subsequent read of word 0 returns 32'h00000000.
REQ-030 SHALL: write 0x20, Cbe=0111, burst data 11111111, 00001111 with Irdy=0, Frame high on second -> Devsel/Trdy low one cycle after address; read 0x20 returns 11111111, 0x24 returns 00001111.
REQ-031 SHALL: address 0x00001F41, Cbe=0010 -> Devsel/Trdy/Stop remain 1, AD never driven, FSM returns IDLE after Frame=Irdy=1.
REQ-032 SHALL: read 0x30 (index 4), burst 6 words -> turnaround cycle with AD=Z, then words 4..7; Stop=0 with word 7; Devsel released after Frame=1.
REQ-033 SHALL: word 2 = 11110000, write 0x28 data 0xAABBCCDD with Cbe=1100 -> word 2 becomes 0x1111CCDD.
REQ-034 SHALL: Rst=1 during DATA of write burst -> outputs return to idle next edge, memory cleared.
